// File: rtl/lwc_do_receiver.sv
// -----------------------------------------------------------------------------
// lwc_do_receiver
//
// Consumes the LWC core's "do" output stream. Segment headers are parsed for
// type, Last flag and byte length; payload words are re-emitted on a
// byte-qualified output stream through a single-entry output register, and
// the status word that terminates an operation is decoded into done/success.
//
// Ports
//   clk        system clock, rising-edge
//   rst        asynchronous active-low reset
//   do_data    word from the core (header, payload or status)
//   do_valid   do_data valid
//   do_last    final word of an operation (expected only on the status word)
//   do_ready   receiver accepts do_data this cycle
//   out_data   payload word, big-endian bytes, unused low bytes forced to zero
//   out_keep   byte-valid mask, bit 3 qualifies out_data[31:24]
//   out_valid  payload word valid
//   out_last   final payload word of a segment whose Last flag is set
//   out_ready  downstream accepts the payload word
//   seg_type   type field of the most recent segment header
//   done       one-cycle pulse after a status word is accepted
//   success    1 when the last status tag was 4'hE, held until the next status
//   proto_err  sticky protocol-error flag, cleared only by reset
// -----------------------------------------------------------------------------
module lwc_do_receiver #(
   parameter int unsigned BUSW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [BUSW-1:0] do_data,
   input  logic            do_valid,
   input  logic            do_last,
   output logic            do_ready,
   output logic [BUSW-1:0] out_data,
   output logic [3:0]      out_keep,
   output logic            out_valid,
   output logic            out_last,
   input  logic            out_ready,
   output logic [3:0]      seg_type,
   output logic            done,
   output logic            success,
   output logic            proto_err
);

   typedef enum logic [1:0] {
      S_HDR   = 2'd0,
      S_DATA  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t          state_q;
   state_t          state_d;

   // Holds do_ready low until the first clock edge after reset release.
   logic            run_q;
   logic [15:0]     rem_q;
   logic            last_flag_q;

   logic [3:0]      tag;
   logic            is_status;
   logic            out_free;
   logic            final_word;
   logic            accept;
   logic            hdr_accept;
   logic            stat_accept;
   logic            pay_accept;
   logic [15:0]     take;
   logic [3:0]      keep_d;
   logic [BUSW-1:0] data_d;

   assign tag        = do_data[31:28];
   assign is_status  = (tag == 4'hE) || (tag == 4'hF);
   // The output register can take a new word if empty or emptying this cycle.
   assign out_free   = !out_valid || out_ready;
   assign final_word = (rem_q <= 16'd4);

   // Bytes consumed by the current payload word: min(rem, 4).
   always_comb begin
      take   = rem_q;
      keep_d = 4'b0000;
      if (rem_q >= 16'd4) begin
         take   = 16'd4;
         keep_d = 4'b1111;
      end else begin
         unique case (rem_q[1:0])
            2'd3:    keep_d = 4'b1110;
            2'd2:    keep_d = 4'b1100;
            2'd1:    keep_d = 4'b1000;
            default: keep_d = 4'b0000;
         endcase
      end
   end

   assign data_d = do_data & {{8{keep_d[3]}}, {8{keep_d[2]}},
                              {8{keep_d[1]}}, {8{keep_d[0]}}};

   // Next-state and do_ready; do_ready never looks at do_valid.
   always_comb begin
      state_d  = state_q;
      do_ready = 1'b0;
      unique case (state_q)
         S_HDR: begin
            do_ready = run_q;
            if (do_valid && run_q && !is_status && (do_data[15:0] != 16'd0))
               state_d = S_DATA;
         end
         S_DATA: begin
            do_ready = out_free;
            // The last payload word goes straight back to header parsing when
            // downstream is taking data; otherwise park until it drains.
            if (do_valid && out_free && final_word)
               state_d = out_ready ? S_HDR : S_DRAIN;
         end
         S_DRAIN: begin
            if (out_ready)
               state_d = S_HDR;
         end
         default: state_d = S_HDR;
      endcase
   end

   assign accept      = do_valid && do_ready;
   assign stat_accept = accept && (state_q == S_HDR) && is_status;
   assign hdr_accept  = accept && (state_q == S_HDR) && !is_status;
   assign pay_accept  = accept && (state_q == S_DATA);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_HDR;
         run_q       <= 1'b0;
         rem_q       <= '0;
         last_flag_q <= 1'b0;
         out_data    <= '0;
         out_keep    <= '0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         seg_type    <= '0;
         done        <= 1'b0;
         success     <= 1'b0;
         proto_err   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
         done    <= stat_accept;

         if (stat_accept) begin
            success <= (tag == 4'hE);
            if (!do_last)
               proto_err <= 1'b1;
         end

         if (hdr_accept) begin
            seg_type    <= tag;
            last_flag_q <= do_data[23];
            rem_q       <= do_data[15:0];
            if (do_last)
               proto_err <= 1'b1;
         end

         // A new payload word replaces the register even while the old one
         // is being taken, so a steady stream has no gaps.
         if (pay_accept) begin
            out_data  <= data_d;
            out_keep  <= keep_d;
            out_valid <= 1'b1;
            out_last  <= last_flag_q && final_word;
            rem_q     <= rem_q - take;
            if (do_last)
               proto_err <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lwc_do_receiver.sv
module tb_lwc_do_receiver;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] do_data = '0;
   logic        do_valid = 1'b0;
   logic        do_last = 1'b0;
   logic        do_ready;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic        out_valid;
   logic        out_last;
   logic        out_ready = 1'b0;
   logic [3:0]  seg_type;
   logic        done;
   logic        success;
   logic        proto_err;

   lwc_do_receiver #(.BUSW(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .do_data   (do_data),
      .do_valid  (do_valid),
      .do_last   (do_last),
      .do_ready  (do_ready),
      .out_data  (out_data),
      .out_keep  (out_keep),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .seg_type  (seg_type),
      .done      (done),
      .success   (success),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Observed and expected output beats: {last, keep, data}.
   logic [36:0] obs_q[$];
   logic [36:0] exp_q[$];
   int          done_cnt = 0;

   // Reference model state, expressed as "bytes still owed to the segment".
   int          m_rem = 0;
   logic        m_lf = 1'b0;
   int          exp_done = 0;
   logic        exp_success = 1'b0;
   logic        exp_perr = 1'b0;
   logic [3:0]  exp_seg = '0;

   task automatic model_reset();
      m_rem       = 0;
      m_lf        = 1'b0;
      exp_success = 1'b0;
      exp_perr    = 1'b0;
      exp_seg     = '0;
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic model_accept(input logic [31:0] w, input logic l);
      int unsigned n;
      logic [31:0] m;
      logic [3:0]  k;
      if (m_rem == 0) begin
         if (w[31:28] == 4'hE || w[31:28] == 4'hF) begin
            exp_done++;
            exp_success = (w[31:28] == 4'hE);
            if (!l) exp_perr = 1'b1;
         end else begin
            exp_seg = w[31:28];
            m_lf    = w[23];
            m_rem   = int'(w[15:0]);
            if (l) exp_perr = 1'b1;
         end
      end else begin
         n = (m_rem < 4) ? m_rem : 4;
         k = '0;
         m = '0;
         for (int unsigned b = 0; b < n; b++) begin
            k[3-b]          = 1'b1;
            m[31-8*b -: 8]  = w[31-8*b -: 8];
         end
         m_rem = m_rem - int'(n);
         exp_q.push_back({m_lf && (m_rem == 0), k, m});
         if (l) exp_perr = 1'b1;
      end
   endtask

   // One clock cycle: drive at the falling edge, observe just after.
   task automatic step(input logic v, input logic [31:0] d, input logic l,
                       input logic ordy, output logic acc);
      @(negedge clk);
      do_valid  = v;
      do_data   = d;
      do_last   = l;
      out_ready = ordy;
      #1;
      acc = v && do_ready;
      if (out_valid && out_ready) obs_q.push_back({out_last, out_keep, out_data});
      if (done) done_cnt++;
   endtask

   task automatic send(input logic [31:0] w, input logic l,
                       input int unsigned rdy_pct, output int tries);
      logic acc;
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 200) begin
         step(1'b1, w, l, ($urandom_range(99) < rdy_pct), acc);
         tries++;
      end
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL send_timeout: word %h not accepted after %0d cycles", w, tries);
      end else begin
         model_accept(w, l);
      end
   endtask

   task automatic idle(input int unsigned n, input int unsigned rdy_pct);
      logic acc;
      for (int unsigned i = 0; i < n; i++)
         step(1'b0, $urandom, 1'b0, ($urandom_range(99) < rdy_pct), acc);
   endtask

   task automatic flush_and_check(input string name);
      int unsigned n;
      idle(6, 100);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s_count: got %0d beats expected %0d", name, obs_q.size(), exp_q.size());
      end
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int unsigned i = 0; i < n; i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL %s_beat%0d: got last=%b keep=%b data=%h expected last=%b keep=%b data=%h",
                     name, i, obs_q[i][36], obs_q[i][35:32], obs_q[i][31:0],
                     exp_q[i][36], exp_q[i][35:32], exp_q[i][31:0]);
         end
      end
      checks++;
      if (done_cnt != exp_done) begin
         errors++;
         $display("FAIL %s_done: got %0d pulses expected %0d", name, done_cnt, exp_done);
      end
      checks++;
      if (success !== exp_success) begin
         errors++;
         $display("FAIL %s_success: got %b expected %b", name, success, exp_success);
      end
      checks++;
      if (proto_err !== exp_perr) begin
         errors++;
         $display("FAIL %s_proto_err: got %b expected %b", name, proto_err, exp_perr);
      end
      checks++;
      if (seg_type !== exp_seg) begin
         errors++;
         $display("FAIL %s_seg_type: got %h expected %h", name, seg_type, exp_seg);
      end
      checks++;
      if (out_valid !== 1'b0 || do_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_idle: got out_valid=%b do_ready=%b expected 0 1", name, out_valid, do_ready);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if ({do_ready, out_valid, out_last, out_keep, out_data, seg_type, done, success, proto_err} !== '0) begin
         errors++;
         $display("FAIL %s: got rdy=%b ov=%b ol=%b keep=%b data=%h type=%h done=%b succ=%b perr=%b expected all zero",
                  name, do_ready, out_valid, out_last, out_keep, out_data, seg_type, done, success, proto_err);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("reset_values");
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (do_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_ready: got %b expected 0", do_ready);
      end
      @(negedge clk);
      #1;
      checks++;
      if (do_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_edge_ready: got %b expected 1", do_ready);
      end
   endtask

   task automatic test_basic();
      int t;
      send(32'h1080_0008, 1'b0, 100, t);
      send(32'hAABB_CCDD, 1'b0, 100, t);
      send(32'h1122_3344, 1'b0, 100, t);
      send(32'hE000_0000, 1'b1, 100, t);
      idle(4, 100);
      checks++;
      if (obs_q.size() != 2 || obs_q[0] !== {1'b0, 4'hF, 32'hAABB_CCDD}
          || obs_q[1] !== {1'b1, 4'hF, 32'h1122_3344}) begin
         errors++;
         $display("FAIL basic_const: got %0d beats first=%h expected 2 beats 0faabbccdd,1f11223344",
                  obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 37'h0);
      end
      checks++;
      if (success !== 1'b1 || proto_err !== 1'b0) begin
         errors++;
         $display("FAIL basic_status: got success=%b perr=%b expected 1 0", success, proto_err);
      end
      flush_and_check("basic");
   endtask

   task automatic test_len5();
      int t;
      send(32'h3000_0005, 1'b0, 100, t);
      send(32'hDEAD_BEEF, 1'b0, 100, t);
      send(32'h5566_7788, 1'b0, 100, t);
      send(32'hE000_0000, 1'b1, 100, t);
      idle(4, 100);
      checks++;
      if (obs_q.size() != 2 || obs_q[1] !== {1'b0, 4'b1000, 32'h5500_0000}) begin
         errors++;
         $display("FAIL len5_tail: got %0d beats last=%h expected 2 beats 0855000000",
                  obs_q.size(), (obs_q.size() > 1) ? obs_q[1] : 37'h0);
      end
      flush_and_check("len5");
   endtask

   task automatic test_len0();
      int t;
      int d0;
      d0 = done_cnt;
      send(32'h4080_0000, 1'b0, 100, t);
      send(32'hF000_0000, 1'b1, 100, t);
      idle(4, 100);
      checks++;
      if (obs_q.size() != 0 || (done_cnt - d0) != 1 || success !== 1'b0) begin
         errors++;
         $display("FAIL len0: got beats=%0d done=%0d success=%b expected 0 1 0",
                  obs_q.size(), done_cnt - d0, success);
      end
      flush_and_check("len0");
   endtask

   task automatic test_backpressure();
      int t;
      logic acc;
      send(32'h2080_000C, 1'b0, 100, t);
      send(32'h0102_0304, 1'b0, 0, t);
      for (int unsigned i = 0; i < 5; i++) begin
         step(1'b1, 32'h0506_0708, 1'b0, 1'b0, acc);
         checks++;
         if (acc !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h0102_0304) begin
            errors++;
            $display("FAIL backpressure_hold%0d: got acc=%b ov=%b data=%h expected 0 1 01020304",
                     i, acc, out_valid, out_data);
         end
      end
      send(32'h0506_0708, 1'b0, 100, t);
      send(32'h090A_0B0C, 1'b0, 100, t);
      flush_and_check("backpressure");
   endtask

   task automatic test_throughput();
      logic [31:0] words [8];
      logic        lasts [8];
      int          t;
      words = '{32'h5000_0010, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                32'h4444_4444, 32'h6080_0004, 32'h7777_7777, 32'hE000_0000};
      lasts = '{0, 0, 0, 0, 0, 0, 0, 1};
      for (int unsigned i = 0; i < 8; i++) begin
         send(words[i], lasts[i], 100, t);
         checks++;
         if (t != 1) begin
            errors++;
            $display("FAIL throughput_word%0d: got %0d cycles expected 1", i, t);
         end
      end
      flush_and_check("throughput");
   endtask

   task automatic test_proto_err();
      int t;
      send(32'hE000_0000, 1'b0, 100, t);
      flush_and_check("perr_status");
      send(32'h7000_0004, 1'b0, 100, t);
      send(32'hCAFE_BABE, 1'b1, 100, t);
      send(32'hF000_0000, 1'b1, 100, t);
      flush_and_check("perr_sticky");
   endtask

   task automatic test_reset_mid();
      int t;
      int d0;
      send(32'h8080_0008, 1'b0, 100, t);
      send(32'h1357_9BDF, 1'b0, 0, t);
      @(negedge clk);
      do_valid = 1'b0;
      rst = 1'b0;
      #1;
      check_reset_outputs("midreset_values");
      d0 = done_cnt;
      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("midreset_held");
      model_reset();
      rst = 1'b1;
      send(32'h9080_0004, 1'b0, 100, t);
      send(32'hCAFE_F00D, 1'b0, 100, t);
      send(32'hE000_0000, 1'b1, 100, t);
      checks++;
      if (done_cnt != d0) begin
         errors++;
         $display("FAIL midreset_no_done: got %0d extra pulses expected 0", done_cnt - d0);
      end
      flush_and_check("midreset");
   endtask

   task automatic test_random();
      int t;
      int unsigned len;
      int unsigned pct;
      logic [31:0] hdr;
      for (int unsigned s = 0; s < 12; s++) begin
         pct = $urandom_range(100, 30);
         len = $urandom_range(20, 0);
         hdr = $urandom;
         hdr[31:28] = 4'($urandom_range(13, 0));
         hdr[15:0]  = 16'(len);
         send(hdr, 1'b0, pct, t);
         for (int unsigned w = 0; w < (len + 3) / 4; w++) begin
            send($urandom, ($urandom_range(15) == 0), pct, t);
            if ($urandom_range(3) == 0) idle($urandom_range(3, 1), pct);
         end
         if ($urandom_range(2) == 0)
            send({($urandom_range(1) == 0) ? 4'hE : 4'hF, 28'($urandom)}, 1'b1, pct, t);
      end
      send(32'hE000_0000, 1'b1, 100, t);
      flush_and_check("random");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_len5();
      test_len0();
      test_backpressure();
      test_throughput();
      test_random();
      test_proto_err();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
